// File: rtl/axi_dma_burst_r.sv
// -----------------------------------------------------------------------------
// axi_dma_burst_r
//
// AXI4 read-side DMA burst engine. A start pulse requests num_beats beats from
// start_addr; the engine splits the transfer into INCR bursts that never exceed
// MAX_BURST beats and never cross a 4 KB page, keeps at most one burst in
// flight, and forwards read data as a zero-latency valid/ready stream.
//
// Ports
//   clk, rst_n              : rising-edge clock, asynchronous active-low reset
//   start                   : request pulse, only looked at while idle
//   start_addr, num_beats   : first byte address (beat aligned), total beats
//   busy, done, error       : status; done is a one-cycle pulse, error is
//                             sticky for the transfer and cleared by a start
//   out_data/valid/ready    : output stream, a direct view of the R channel
//   m_axi_ar*               : AXI read address channel (master side)
//   m_axi_r*                : AXI read data channel (master side)
// -----------------------------------------------------------------------------
module axi_dma_burst_r #(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 30,
  parameter int LEN_W     = 8,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 16,
  parameter int ID_W      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  num_beats,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [LEN_W-1:0]  m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic [3:0]        m_axi_arqos,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [ID_W-1:0]   m_axi_rid,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  localparam int BYTES  = DATA_W / 8;
  localparam int SIZE   = $clog2(BYTES);
  // Burst length in beats can reach 2^LEN_W, so it needs one bit more than arlen.
  localparam int BLEN_W = LEN_W + 1;
  // Common widths for the min() comparisons so no operand is silently truncated.
  localparam int PW     = (BLEN_W > 13) ? BLEN_W : 13;
  localparam int RW     = (CNT_W > BLEN_W) ? CNT_W : BLEN_W;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_remaining;
  logic [BLEN_W-1:0]   r_blen;
  logic [BLEN_W-1:0]   r_beat_cnt;
  logic                r_done;
  logic                r_error;

  logic [11:0]         w_page_off;
  logic [PW-1:0]       w_to_4k;
  logic [BLEN_W-1:0]   w_cap;
  logic [BLEN_W-1:0]   w_blen;
  logic                w_beat;
  logic                w_last_in_burst;
  logic                w_beat_err;

  // Offset inside the current 4 KB page; narrow address spaces are all one page.
  generate
    if (ADDR_W >= 12) begin : g_page_wide
      assign w_page_off = r_addr[11:0];
    end else begin : g_page_narrow
      assign w_page_off = 12'(r_addr);
    end
  endgenerate

  // Beats left before the page boundary; the start address is beat aligned.
  assign w_to_4k = (PW'(4096) - PW'(w_page_off)) >> SIZE;
  assign w_cap   = (w_to_4k < PW'(MAX_BURST)) ? BLEN_W'(w_to_4k) : BLEN_W'(MAX_BURST);
  assign w_blen  = (RW'(r_remaining) < RW'(w_cap)) ? BLEN_W'(r_remaining) : w_cap;

  assign w_beat          = (r_state == S_DATA) && m_axi_rvalid && out_ready;
  assign w_last_in_burst = (r_beat_cnt == r_blen - BLEN_W'(1));
  // rlast must be high exactly on the final beat of the burst, never earlier.
  assign w_beat_err      = (m_axi_rresp != 2'b00) || (m_axi_rid != '0) ||
                           (m_axi_rlast != w_last_in_burst);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start && (num_beats != '0)) w_next = S_ADDR;
      S_ADDR: if (m_axi_arready)              w_next = S_DATA;
      S_DATA: if (w_beat && w_last_in_burst)
                w_next = (r_remaining == CNT_W'(1)) ? S_IDLE : S_ADDR;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: address, counters, status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_blen      <= '0;
      r_beat_cnt  <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_error <= 1'b0;
            if (num_beats == '0) begin
              r_done <= 1'b1;
            end else begin
              r_addr      <= start_addr;
              r_remaining <= num_beats;
            end
          end
        end
        S_ADDR: begin
          // Freeze the burst length for the data phase, where remaining moves.
          if (m_axi_arready) begin
            r_blen     <= w_blen;
            r_beat_cnt <= '0;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_remaining <= r_remaining - CNT_W'(1);
            r_beat_cnt  <= r_beat_cnt + BLEN_W'(1);
            if (w_beat_err) r_error <= 1'b1;
            if (w_last_in_burst) begin
              if (r_remaining == CNT_W'(1)) r_done <= 1'b1;
              else r_addr <= r_addr + (ADDR_W'(r_blen) << SIZE);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy  = (r_state != S_IDLE);
  assign done  = r_done;
  assign error = r_error;

  // AR fields derive from registers that only change outside ADDR, so they
  // hold steady for the whole handshake.
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = LEN_W'(w_blen - BLEN_W'(1));
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0010;
  assign m_axi_arprot  = 3'b010;
  assign m_axi_arqos   = 4'b0000;
  assign m_axi_arvalid = (r_state == S_ADDR);

  assign m_axi_rready  = (r_state == S_DATA) && out_ready;
  assign out_valid     = (r_state == S_DATA) && m_axi_rvalid;
  assign out_data      = m_axi_rdata;

endmodule

// File: tb/tb_axi_dma_burst_r.sv
// -----------------------------------------------------------------------------
// tb_axi_dma_burst_r
//
// Directed bench for axi_dma_burst_r with default parameters. A small AXI read
// slave answers each accepted burst with beats whose data encode their byte
// address, so order, loss and duplication show up as data differences. The
// slave logs AR requests, output beats and done pulses; each test task compares
// the logs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_axi_dma_burst_r;

  localparam int DATA_W    = 256;
  localparam int ADDR_W    = 30;
  localparam int LEN_W     = 8;
  localparam int MAX_BURST = 16;
  localparam int CNT_W     = 16;
  localparam int ID_W      = 1;
  localparam int BYTES     = DATA_W / 8;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [CNT_W-1:0]  num_beats;
  logic              busy, done, error;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  axi_dma_burst_r #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
    .MAX_BURST(MAX_BURST), .CNT_W(CNT_W), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .start_addr(start_addr), .num_beats(num_beats),
    .busy(busy), .done(done), .error(error),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
    .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arqos(arqos),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Slave configuration and logs
  bit                cfg_toggle = 1'b0;
  int                cfg_bad_resp_idx = -1;
  int                cfg_early_last_idx = -1;
  logic [ADDR_W-1:0] ar_addr_q[$];
  int                ar_len_q[$];
  logic [DATA_W-1:0] beat_q[$];
  int                done_cnt, done_cyc, last_beat_cyc;
  int                err_proto, err_attr, err_iface;
  int                cyc = 0;
  int                xfer_beat = 0;

  // Slave internal state
  bit                sl_pending = 1'b0;
  logic [ADDR_W-1:0] sl_addr, sl_ar_addr;
  int                sl_len, sl_ar_len, sl_idx;
  bit                f_ar = 1'b0, f_r = 1'b0;

  function automatic logic [DATA_W-1:0] beat_word(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = 32'hA500_0000 ^ 32'(a);
    return {(DATA_W/32){w}};
  endfunction

  // Number of logged beats whose data differ from a contiguous read at a0.
  function automatic int data_errs(input logic [ADDR_W-1:0] a0);
    int e = 0;
    for (int i = 0; i < beat_q.size(); i++)
      if (beat_q[i] !== beat_word(a0 + ADDR_W'(i * BYTES))) e++;
    return e;
  endfunction

  // AXI slave + monitor. Inputs change on the falling edge; one time unit
  // later the settled DUT outputs decide which handshakes the next rising edge
  // completes, and those take effect at the following falling edge.
  initial begin
    arready = 1'b1; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    rlast = 1'b0; rid = '0; out_ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sl_pending = 1'b0; f_ar = 1'b0; f_r = 1'b0;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        continue;
      end
      if (f_r) begin
        xfer_beat++;
        if (sl_idx == sl_len) sl_pending = 1'b0;
        else sl_idx++;
      end
      if (f_ar) begin
        sl_pending = 1'b1; sl_addr = sl_ar_addr; sl_len = sl_ar_len; sl_idx = 0;
      end
      f_ar = 1'b0; f_r = 1'b0;
      out_ready = cfg_toggle ? ~out_ready : 1'b1;
      rvalid = sl_pending;
      rdata  = sl_pending ? beat_word(sl_addr + ADDR_W'(sl_idx * BYTES)) : '0;
      rlast  = sl_pending && ((sl_idx == sl_len) || (xfer_beat == cfg_early_last_idx));
      rresp  = (sl_pending && (xfer_beat == cfg_bad_resp_idx)) ? 2'b10 : 2'b00;
      #1;
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (arvalid === 1'b1) begin
        if (sl_pending) err_proto++;
        if (arready) begin
          f_ar = 1'b1; sl_ar_addr = araddr; sl_ar_len = int'(arlen);
          ar_addr_q.push_back(araddr); ar_len_q.push_back(int'(arlen));
          if (arid !== '0 || arsize !== 3'd5 || arburst !== 2'b01 || arlock !== 1'b0 ||
              arcache !== 4'b0010 || arprot !== 3'b010 || arqos !== 4'b0000) err_attr++;
        end
      end
      if (sl_pending) begin
        if (rready !== out_ready || out_valid !== rvalid) err_iface++;
        if (rvalid && rready) begin
          f_r = 1'b1; beat_q.push_back(out_data); last_beat_cyc = cyc;
        end
      end else if (rready !== 1'b0 || out_valid !== 1'b0) begin
        err_iface++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic clear_logs();
    ar_addr_q.delete(); ar_len_q.delete(); beat_q.delete();
    done_cnt = 0; done_cyc = -1; last_beat_cyc = -1;
    err_proto = 0; err_attr = 0; err_iface = 0; xfer_beat = 0;
  endtask

  // Pulses start for one cycle; returns 2 time units after the next falling
  // edge with s_cyc set to the cycle in which start was presented.
  task automatic start_xfer(input logic [ADDR_W-1:0] a, input int n, output int s_cyc);
    @(negedge clk);
    start = 1'b1; start_addr = a; num_beats = CNT_W'(n);
    #2 s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    #2;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0) begin ok = 1'b1; break; end
      @(negedge clk); #2;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start_addr = '0; num_beats = '0;
    #23;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else passed++;
    total++; if (arvalid !== 1'b0) $display("FAIL reset_arvalid: got %b want 0", arvalid); else passed++;
    total++; if (rready !== 1'b0) $display("FAIL reset_rready: got %b want 0", rready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    @(negedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic test_single_burst();
    int s; bit ok;
    clear_logs();
    start_xfer(30'h0, 7, s);
    wait_done(100, ok);
    total++; if (!ok) $display("FAIL single_timeout: got no done want done"); else passed++;
    total++; if (ar_addr_q.size() !== 1) $display("FAIL single_ar_count: got %0d want 1", ar_addr_q.size()); else passed++;
    if (ar_addr_q.size() == 1) begin
      total++; if (ar_addr_q[0] !== 30'h0) $display("FAIL single_araddr: got %0h want 0", ar_addr_q[0]); else passed++;
      total++; if (ar_len_q[0] !== 6) $display("FAIL single_arlen: got %0d want 6", ar_len_q[0]); else passed++;
    end
    total++; if (beat_q.size() !== 7) $display("FAIL single_beats: got %0d want 7", beat_q.size()); else passed++;
    total++; if (data_errs(30'h0) !== 0) $display("FAIL single_data: got %0d bad beats want 0", data_errs(30'h0)); else passed++;
    total++; if (done_cyc !== last_beat_cyc + 1) $display("FAIL single_done_latency: got cycle %0d want %0d", done_cyc, last_beat_cyc + 1); else passed++;
    total++; if (error !== 1'b0) $display("FAIL single_error: got %b want 0", error); else passed++;
    total++; if (err_attr !== 0) $display("FAIL single_ar_attrs: got %0d bad requests want 0", err_attr); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL single_busy_after: got %b want 0", busy); else passed++;
  endtask

  task automatic test_4k_split();
    int s; bit ok;
    logic [ADDR_W-1:0] exp_addr [4] = '{30'h0F80, 30'h1000, 30'h1200, 30'h1400};
    int                exp_len  [4] = '{3, 15, 15, 3};
    clear_logs();
    start_xfer(30'h0F80, 40, s);
    wait_done(400, ok);
    total++; if (!ok) $display("FAIL split_timeout: got no done want done"); else passed++;
    total++; if (ar_addr_q.size() !== 4) $display("FAIL split_ar_count: got %0d want 4", ar_addr_q.size()); else passed++;
    for (int i = 0; i < 4 && i < ar_addr_q.size(); i++) begin
      total++;
      if (ar_addr_q[i] !== exp_addr[i] || ar_len_q[i] !== exp_len[i])
        $display("FAIL split_burst%0d: got addr %0h len %0d want addr %0h len %0d",
                 i, ar_addr_q[i], ar_len_q[i], exp_addr[i], exp_len[i]);
      else passed++;
    end
    total++; if (beat_q.size() !== 40) $display("FAIL split_beats: got %0d want 40", beat_q.size()); else passed++;
    total++; if (data_errs(30'h0F80) !== 0) $display("FAIL split_data: got %0d bad beats want 0", data_errs(30'h0F80)); else passed++;
    total++; if (err_proto !== 0) $display("FAIL split_outstanding: got %0d overlaps want 0", err_proto); else passed++;
  endtask

  task automatic test_backpressure();
    int s; bit ok;
    clear_logs();
    cfg_toggle = 1'b1;
    start_xfer(30'h2000, 16, s);
    wait_done(300, ok);
    cfg_toggle = 1'b0;
    total++; if (!ok) $display("FAIL bp_timeout: got no done want done"); else passed++;
    total++; if (beat_q.size() !== 16) $display("FAIL bp_beats: got %0d want 16", beat_q.size()); else passed++;
    total++; if (data_errs(30'h2000) !== 0) $display("FAIL bp_data: got %0d bad beats want 0", data_errs(30'h2000)); else passed++;
    total++; if (err_iface !== 0) $display("FAIL bp_rready_mirror: got %0d bad cycles want 0", err_iface); else passed++;
  endtask

  task automatic test_bad_resp();
    int s; bit ok;
    clear_logs();
    cfg_bad_resp_idx = 2;
    start_xfer(30'h3000, 8, s);
    wait_done(200, ok);
    cfg_bad_resp_idx = -1;
    total++; if (!ok) $display("FAIL resp_timeout: got no done want done"); else passed++;
    total++; if (error !== 1'b1) $display("FAIL resp_error: got %b want 1", error); else passed++;
    total++; if (beat_q.size() !== 8) $display("FAIL resp_beats: got %0d want 8", beat_q.size()); else passed++;
    total++; if (data_errs(30'h3000) !== 0) $display("FAIL resp_data: got %0d bad beats want 0", data_errs(30'h3000)); else passed++;
    clear_logs();
    start_xfer(30'h3000, 1, s);
    total++; if (error !== 1'b0 || busy !== 1'b1) $display("FAIL resp_clear_on_start: got error %b busy %b want error 0 busy 1", error, busy); else passed++;
    wait_done(50, ok);
    total++; if (!ok || error !== 1'b0) $display("FAIL resp_clean_rerun: got done %b error %b want done 1 error 0", ok, error); else passed++;
  endtask

  task automatic test_zero_beats();
    int s; bit ok;
    clear_logs();
    start_xfer(30'h500, 0, s);
    wait_done(5, ok);
    total++; if (!ok) $display("FAIL zero_timeout: got no done want done"); else passed++;
    total++; if (done_cyc !== s + 1) $display("FAIL zero_done_cycle: got %0d want %0d", done_cyc, s + 1); else passed++;
    total++; if (ar_addr_q.size() !== 0) $display("FAIL zero_ar_traffic: got %0d requests want 0", ar_addr_q.size()); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_early_last();
    int s; bit ok;
    clear_logs();
    cfg_early_last_idx = 4;
    start_xfer(30'h4000, 8, s);
    wait_done(200, ok);
    cfg_early_last_idx = -1;
    total++; if (!ok) $display("FAIL last_timeout: got no done want done"); else passed++;
    total++; if (ar_len_q.size() !== 1 || ar_len_q[0] !== 7) $display("FAIL last_arlen: got %0d requests want one with arlen 7", ar_len_q.size()); else passed++;
    total++; if (error !== 1'b1) $display("FAIL last_error: got %b want 1", error); else passed++;
    total++; if (beat_q.size() !== 8) $display("FAIL last_beats: got %0d want 8", beat_q.size()); else passed++;
    total++; if (done_cyc !== last_beat_cyc + 1) $display("FAIL last_done_cycle: got %0d want %0d", done_cyc, last_beat_cyc + 1); else passed++;
  endtask

  task automatic test_ignore_busy();
    int s; bit ok;
    clear_logs();
    start_xfer(30'h100, 4, s);
    @(negedge clk);
    start = 1'b1; start_addr = 30'h800; num_beats = CNT_W'(3);
    @(negedge clk);
    start = 1'b0;
    #2;
    wait_done(100, ok);
    repeat (6) @(negedge clk);
    #2;
    total++; if (!ok || done_cnt !== 1) $display("FAIL busy_done_count: got %0d want 1", done_cnt); else passed++;
    total++; if (ar_addr_q.size() !== 1) $display("FAIL busy_ar_count: got %0d want 1", ar_addr_q.size()); else passed++;
    total++; if (beat_q.size() !== 4 || data_errs(30'h100) !== 0) $display("FAIL busy_beats: got %0d beats want 4 from 0x100", beat_q.size()); else passed++;
  endtask

  task automatic test_wrap();
    int s; bit ok;
    clear_logs();
    start_xfer(30'h3FFF_FFC0, 4, s);
    wait_done(100, ok);
    total++; if (!ok) $display("FAIL wrap_timeout: got no done want done"); else passed++;
    total++; if (ar_addr_q.size() !== 2) $display("FAIL wrap_ar_count: got %0d want 2", ar_addr_q.size()); else passed++;
    if (ar_addr_q.size() == 2) begin
      total++;
      if (ar_addr_q[0] !== 30'h3FFF_FFC0 || ar_len_q[0] !== 1 || ar_addr_q[1] !== 30'h0 || ar_len_q[1] !== 1)
        $display("FAIL wrap_bursts: got %0h/%0d %0h/%0d want 3fffffc0/1 0/1",
                 ar_addr_q[0], ar_len_q[0], ar_addr_q[1], ar_len_q[1]);
      else passed++;
    end
    total++; if (beat_q.size() !== 4 || data_errs(30'h3FFF_FFC0) !== 0) $display("FAIL wrap_data: got %0d beats want 4 in order", beat_q.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    int s; bit ok;
    clear_logs();
    start_xfer(30'h0, 16, s);
    for (int i = 0; i < 200; i++) begin
      if (beat_q.size() >= 4) break;
      @(negedge clk); #2;
    end
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passed++;
    total++; if (arvalid !== 1'b0 || rready !== 1'b0) $display("FAIL midrst_axi: got arvalid %b rready %b want 0 0", arvalid, rready); else passed++;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    total++; if (done_cnt !== 0) $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt); else passed++;
    clear_logs();
    start_xfer(30'h40, 2, s);
    wait_done(50, ok);
    total++; if (!ok) $display("FAIL midrst_restart_timeout: got no done want done"); else passed++;
    total++; if (ar_len_q.size() !== 1 || ar_addr_q[0] !== 30'h40 || ar_len_q[0] !== 1) $display("FAIL midrst_restart_ar: got %0d requests want one at 40 len 1", ar_len_q.size()); else passed++;
    total++; if (beat_q.size() !== 2 || data_errs(30'h40) !== 0 || error !== 1'b0) $display("FAIL midrst_restart_data: got %0d beats error %b want 2 beats error 0", beat_q.size(), error); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_4k_split();
    test_backpressure();
    test_bad_resp();
    test_zero_beats();
    test_early_last();
    test_ignore_busy();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
